imem_loader: RTL and testbench

Boot-time program loader for the instruction memory: accepts a framed little-endian byte stream over a valid/ready handshake, assembles 32-bit words and drives a word-addressed write port into instruction memory. It sits between the host link (UART/debug receiver) and the instruction memory's write side. The CPU core is held in reset until the complete image has been written.

---
 rtl/imem_loader_if.sv | 15 +
 rtl/imem_loader.sv | 181 ++++++++++++++++++
 tb/tb_imem_loader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream valid/ready channel feeding the imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot loader turning a framed little-endian byte stream into
//               instruction-memory word writes; optional trailing checksum
//               byte enabled by IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    imem_loader_if.slave            s_in,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [31:0]             mem_wdata,
    output logic                    cpu_rst_n,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [16:0] c_CAPACITY = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_CNT_LO = 3'd0,
        S_CNT_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [31:0]             r_mem_wdata;
    logic                    r_cpu_rst_n;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [7:0]              r_cnt_lo;
    logic [15:0]             r_remaining;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [1:0]              r_byte_idx;
    logic [23:0]             r_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]              r_sum;
`endif

    logic                    w_xfer;
    logic [15:0]             w_cnt;
    logic [31:0]             w_word;

    assign w_xfer = s_in.in_valid && r_in_ready;
    assign w_cnt  = {s_in.in_data, r_cnt_lo};
    // Bytes enter at the top and shift down, so the first byte lands in [7:0].
    assign w_word = {s_in.in_data, r_word};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_CNT_LO;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cnt_lo    <= '0;
            r_remaining <= '0;
            r_addr      <= '0;
            r_byte_idx  <= '0;
            r_word      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_CNT_LO: begin
                    r_in_ready <= 1'b1;
                    if (w_xfer) begin
                        r_cnt_lo <= s_in.in_data;
                        r_busy   <= 1'b1;
                        r_state  <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (w_xfer) begin
                        r_remaining <= w_cnt;
                        if (w_cnt == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state     <= S_CSUM;
`else
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_cpu_rst_n <= 1'b1;
`endif
                        end else if ({1'b0, w_cnt} > c_CAPACITY) begin
                            r_state    <= S_ERR;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_word     <= w_word[31:8];
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum      <= r_sum + s_in.in_data;
`endif
                        if (r_byte_idx == 2'd3) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_addr;
                            r_mem_wdata <= w_word;
                            r_addr      <= r_addr + 1'b1;
                            r_remaining <= r_remaining - 16'd1;
                            if (r_remaining == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                r_state    <= S_CSUM;
`else
                                // done rises one cycle later, after the final write pulse.
                                r_state    <= S_DONE;
                                r_in_ready <= 1'b0;
                                r_busy     <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_xfer) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (s_in.in_data == r_sum) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_cpu_rst_n <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    r_done      <= 1'b1;
                    r_cpu_rst_n <= 1'b1;
                end
                S_ERR: begin
                    r_err <= 1'b1;
                end
                default: begin
                    r_state <= S_CNT_LO;
                end
            endcase
        end
    end

    assign s_in.in_ready = r_in_ready;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign cpu_rst_n     = r_cpu_rst_n;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader: fixed frame table, corner
//               sequences and random frames against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int AW  = 10;
    localparam int CAP = 1 << AW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_wdata;
    logic            cpu_rst_n;
    logic            busy;
    logic            done;
    logic            err;

    imem_loader_if s ();

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_in      (s),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  b [0:11];
        int          len;
        int          gap;
        bit          exp_done;
        int          exp_nwr;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    wr_t        wr_q[$];
    int         acc_q[$];
    int         done_cyc = -1;
    int         err_cyc  = -1;

    // Model results: exp_wr[].cyc holds the index of the byte that completes the word.
    logic [7:0] frame[$];
    wr_t        exp_wr[$];
    int         exp_cons;
    bit         exp_done;
    bit         exp_err;
    int         exp_delay;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && s.in_valid && s.in_ready) acc_q.push_back(cyc);
        if (mem_we) wr_q.push_back('{cyc, mem_addr, mem_wdata});
        if (done && done_cyc < 0) done_cyc = cyc;
        if (err && err_cyc < 0) err_cyc = cyc;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic model();
        int n;
        logic [7:0] sum;
        exp_wr.delete();
        n = int'(frame[0]) + 256 * int'(frame[1]);
        if (n > CAP) begin
            exp_cons  = 2;
            exp_done  = 1'b0;
            exp_err   = 1'b1;
            exp_delay = 1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            wr_t w;
            w.cyc  = 2 + 4 * k + 3;
            w.addr = AW'(k);
            w.data = {frame[2+4*k+3], frame[2+4*k+2], frame[2+4*k+1], frame[2+4*k]};
            exp_wr.push_back(w);
        end
        sum = 8'h00;
        for (int i = 2; i < 2 + 4 * n; i++) sum = sum + frame[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_cons  = 3 + 4 * n;
        exp_done  = (frame[2 + 4 * n] == sum);
        exp_err   = !exp_done;
        exp_delay = 1;
`else
        exp_cons  = 2 + 4 * n;
        exp_done  = 1'b1;
        exp_err   = 1'b0;
        exp_delay = (n == 0) ? 1 : 2;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        s.in_valid = 1'b1;
        s.in_data  = b;
        t = 0;
        @(negedge clk);
        while (!s.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = s.in_ready;
        @(posedge clk);
        #1;
        s.in_valid = 1'b0;
    endtask

    task automatic reset_dut();
        s.in_valid = 1'b0;
        s.in_data  = 8'h00;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", s.in_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_cpu_rst_n", cpu_rst_n, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_q.delete();
        acc_q.delete();
        done_cyc = -1;
        err_cyc  = -1;
    endtask

    task automatic run_frame(input int gap_max, input string nm);
        bit ok;
        int last;
        reset_dut();
        model();
        for (int i = 0; i < exp_cons; i++) begin
            send_byte(frame[i], (gap_max == 0) ? 0 : $urandom_range(gap_max, 0), ok);
            if (!ok) break;
        end
        repeat (3) @(negedge clk);
        chk({nm, "_accepted"}, acc_q.size(), exp_cons);
        chk({nm, "_nwr"}, wr_q.size(), exp_wr.size());
        for (int j = 0; j < exp_wr.size() && j < wr_q.size(); j++) begin
            chk({nm, "_addr"}, wr_q[j].addr, exp_wr[j].addr);
            chk({nm, "_data"}, wr_q[j].data, exp_wr[j].data);
            if (exp_wr[j].cyc < acc_q.size())
                chk({nm, "_wr_latency"}, wr_q[j].cyc - acc_q[exp_wr[j].cyc], 1);
        end
        chk({nm, "_done"}, done, exp_done);
        chk({nm, "_err"}, err, exp_err);
        chk({nm, "_cpu_rst_n"}, cpu_rst_n, exp_done);
        chk({nm, "_busy"}, busy, 1'b0);
        chk({nm, "_in_ready"}, s.in_ready, 1'b0);
        last = (acc_q.size() > 0) ? acc_q[acc_q.size() - 1] : -100;
        if (exp_done) chk({nm, "_done_time"}, done_cyc - last, exp_delay);
        else          chk({nm, "_err_time"}, err_cyc - last, exp_delay);
        @(posedge clk);
        #1;
        s.in_valid = 1'b1;
        s.in_data  = 8'h5A;
        repeat (4) @(negedge clk);
        chk({nm, "_extra_ignored"}, acc_q.size(), exp_cons);
        @(posedge clk);
        #1;
        s.in_valid = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[6];
        bit         ok;
        int         n;
        logic [7:0] sum;

`ifdef IMEM_LOADER_CHECKSUM_EN
        tbl[0] = '{'{8'h02,8'h00,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE,8'h4C,8'h00}, 11, 0, 1'b1, 2, 32'h12345678, 32'hDEADBEEF};
        tbl[1] = '{'{8'h02,8'h00,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE,8'h4C,8'h00}, 11, 5, 1'b1, 2, 32'h12345678, 32'hDEADBEEF};
        tbl[2] = '{'{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 0, 1'b1, 0, 32'h0, 32'h0};
        tbl[3] = '{'{8'h01,8'h04,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 0, 1'b0, 0, 32'h0, 32'h0};
        tbl[4] = '{'{8'h01,8'h00,8'h01,8'h02,8'h03,8'h04,8'h0A,8'h00,8'h00,8'h00,8'h00,8'h00}, 7, 0, 1'b1, 1, 32'h04030201, 32'h0};
        tbl[5] = '{'{8'h01,8'h00,8'h01,8'h02,8'h03,8'h04,8'h0B,8'h00,8'h00,8'h00,8'h00,8'h00}, 7, 2, 1'b0, 1, 32'h04030201, 32'h0};
`else
        tbl[0] = '{'{8'h02,8'h00,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE,8'h00,8'h00}, 10, 0, 1'b1, 2, 32'h12345678, 32'hDEADBEEF};
        tbl[1] = '{'{8'h02,8'h00,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE,8'h00,8'h00}, 10, 5, 1'b1, 2, 32'h12345678, 32'hDEADBEEF};
        tbl[2] = '{'{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 0, 1'b1, 0, 32'h0, 32'h0};
        tbl[3] = '{'{8'h01,8'h04,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 0, 1'b0, 0, 32'h0, 32'h0};
        tbl[4] = '{'{8'h01,8'h00,8'h44,8'h33,8'h22,8'h11,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 6, 0, 1'b1, 1, 32'h11223344, 32'h0};
        tbl[5] = '{'{8'h01,8'h00,8'h01,8'h02,8'h03,8'h04,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 6, 3, 1'b1, 1, 32'h04030201, 32'h0};
`endif

        s.in_valid = 1'b0;
        s.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            frame.delete();
            for (int i = 0; i < tbl[v].len; i++) frame.push_back(tbl[v].b[i]);
            run_frame(tbl[v].gap, "tbl");
            chk("tbl_vec_done", done, tbl[v].exp_done);
            chk("tbl_vec_nwr", wr_q.size(), tbl[v].exp_nwr);
            if (tbl[v].exp_nwr >= 1 && wr_q.size() >= 1) chk("tbl_vec_w0", wr_q[0].data, tbl[v].w0);
            if (tbl[v].exp_nwr >= 2 && wr_q.size() >= 2) chk("tbl_vec_w1", wr_q[1].data, tbl[v].w1);
        end

        // Reset after a partial word: nothing written, loader restarts at address 0.
        reset_dut();
        send_byte(8'h01, 0, ok);
        send_byte(8'h00, 0, ok);
        send_byte(8'hAA, 0, ok);
        send_byte(8'hBB, 0, ok);
        repeat (2) @(negedge clk);
        chk("partial_busy", busy, 1'b1);
        chk("partial_nwr", wr_q.size(), 0);
        frame = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame.push_back(8'hAA);
`endif
        run_frame(0, "after_rst");

        // Reset coinciding with the 4th byte: the pending write must not appear.
        reset_dut();
        send_byte(8'h01, 0, ok);
        send_byte(8'h00, 0, ok);
        send_byte(8'hAA, 0, ok);
        send_byte(8'hBB, 0, ok);
        send_byte(8'hCC, 0, ok);
        s.in_valid = 1'b1;
        s.in_data  = 8'hDD;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;
        s.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_suppress_nwr", wr_q.size(), 0);
        chk("rst_suppress_busy", busy, 1'b0);

        // Largest legal image and the largest oversize count.
        frame = '{8'h00, 8'h04};
        sum = 8'h00;
        for (int i = 0; i < 4 * CAP; i++) begin
            frame.push_back(8'($urandom));
            sum = sum + frame[frame.size() - 1];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame.push_back(sum);
`endif
        run_frame(0, "max_img");
        frame = '{8'hFF, 8'hFF, 8'h01, 8'h02};
        run_frame(2, "ovf_max");

        for (int r = 0; r < 16; r++) begin
            frame.delete();
            if ($urandom_range(9, 0) == 0) n = CAP + 1 + $urandom_range(200, 0);
            else                           n = $urandom_range(6, 0);
            frame.push_back(8'(n));
            frame.push_back(8'(n >> 8));
            sum = 8'h00;
            for (int i = 0; i < ((n > CAP) ? 3 : 4 * n); i++) begin
                frame.push_back(8'($urandom));
                sum = sum + frame[frame.size() - 1];
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if ($urandom_range(3, 0) == 0) frame.push_back(sum + 8'($urandom_range(255, 1)));
            else                           frame.push_back(sum);
`endif
            run_frame($urandom_range(3, 0), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
